dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data load/store port.
- The core acts as initiator: it presents a request with address, write-enable and write data. This block accepts the request, inserts a programmable number of wait states, commits the store or fetches the load word, then pulses ready.
- Replaces the zero-latency data memory so the core can be exercised against realistic memory timing.
- Word-organised storage, one outstanding transaction at a time.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..4096.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response; 0..15.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be DEPTH_WORDS*4 aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronous to clk by the system.
- req  in  1  initiator request valid; held high until ready is seen.
- we  in  1  1 = store, 0 = load; sampled at acceptance.
- addr  in  32  byte address; sampled at acceptance.
- wdata  in  32  store data; sampled at acceptance.
- ready  out  1  one-cycle pulse: transaction complete.
- rdata  out  32  load data; valid only while ready=1; 0 otherwise.
- err  out  1  error flag; valid only while ready=1 (see Optional Feature).
- busy  out  1  1 from the acceptance edge until the ready cycle inclusive.

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, ready=0, rdata=0, err=0, busy=0, latched request registers=0. Storage array contents are not reset.
- FSM states:
  - IDLE: on a rising edge with req=1, latch we/addr/wdata and set busy=1. Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At counter==0, go to RESP.
  - RESP: ready=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: ready is high in cycle N+WAIT_CYCLES+1, where N is the acceptance cycle. With WAIT_CYCLES=0, ready is high in the cycle after acceptance.
- Word index: (addr_latched - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits. Out-of-window addresses wrap modulo DEPTH_WORDS unless the optional feature is enabled.
- Store: the array write occurs on the edge entering RESP. During the RESP cycle, rdata=0.
- Load: rdata is registered on the edge entering RESP from the array word at that time. It returns to 0 on the next edge.
- Input changes after acceptance (addr, wdata, we, or req dropping) are ignored. The transaction always completes. Dropping req early is a protocol violation but must not hang the FSM.
- Back-to-back: req is not sampled in WAIT or RESP. A req held high through RESP is accepted as a new transaction in the following IDLE cycle, so there is a minimum one idle cycle between ready pulses.
- Read-after-write to the same word in consecutive transactions returns the new data.
- Reset mid-transaction: immediate return to IDLE. A store not yet at the RESP edge is not committed. No ready pulse is produced for the aborted transaction.
- err is always 0 when the optional feature is compiled out.

Optional Feature:
- Macro: DMEM_RESPONDER_ADDR_CHECK_EN.
- Defined: at acceptance, flag the transaction bad if addr[1:0]!=0 or addr is outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4). A bad transaction still takes full latency and returns ready=1 with err=1 and rdata=0. A bad store does not modify the array.
- Undefined: addr[1:0] are ignored, addresses wrap, and err is tied 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles while req=1 → ready=0, busy=0, rdata=0, err=0 throughout; no transaction accepted.
- Store/load, WAIT_CYCLES=2: store 32'hDEAD_BEEF to 0x10, accepted at cycle N → ready exactly at N+3. Then load 0x10 → rdata=32'hDEAD_BEEF in its ready cycle, 0 in the cycles before and after.
- Back-to-back with req held high: store 32'h1 to 0x4, then load 0x4 → second acceptance one cycle after the first ready; load returns 32'h1.
- WAIT_CYCLES=0 with addr changed after acceptance: store to 0x8, addr driven to 0xC in the next cycle → ready at N+1; a load of 0x8 returns the stored data and 0xC is unchanged.
- Reset mid-store: store 32'hCAFE_0000 to 0x20 (old value 32'h5), assert rst during WAIT → no ready. After reset release, load 0x20 → 32'h5.
- With DMEM_RESPONDER_ADDR_CHECK_EN, DEPTH_WORDS=256, BASE_ADDR=0:
  - Store 32'h7 to 0x402 → ready with err=1.
  - Store to 0x400 → err=1; a load of 0x0 is unchanged.
  - Load 0x3FC → err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data load/store port.
// It accepts one request at a time and inserts WAIT_CYCLES wait states. It
// then commits the store or fetches the load word, and pulses ready for one
// cycle.
//
// Optional build macro DMEM_RESPONDER_ADDR_CHECK_EN: misaligned or
// out-of-window addresses complete with err=1 and rdata=0, and a bad store
// leaves the array untouched. Without the macro, addr[1:0] are ignored,
// addresses wrap modulo DEPTH_WORDS, and err is held at 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; a request on a rising edge is accepted
// WAIT    | wait states counting down; inputs are ignored
// RESP    | ready=1 for one cycle; store already committed, load data valid

module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam bit          HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0]  WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    wait_cnt;
  logic [3:0]    wait_cnt_nxt;

  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;

  logic          accept;
  logic          commit;
  logic          txn_we;
  logic [31:0]   txn_addr;
  logic [31:0]   txn_wdata;
  logic          txn_bad;
  logic [AW-1:0] txn_idx;
  logic          mem_we;

  logic [31:0]   mem [DEPTH_WORDS];

  assign accept = (state == ST_IDLE) && req;

  // The commit edge can coincide with acceptance when there are no wait
  // states. In that case the live inputs are used instead of the latches.
  assign txn_we    = (state == ST_IDLE) ? we    : lat_we;
  assign txn_addr  = (state == ST_IDLE) ? addr  : lat_addr;
  assign txn_wdata = (state == ST_IDLE) ? wdata : lat_wdata;
  assign txn_idx   = AW'((txn_addr - BASE_ADDR) >> 2);

`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
  logic lat_bad;
  logic in_bad;
  logic err_q;

  // The unsigned offset compare also catches addresses below BASE_ADDR,
  // because the subtraction wraps them to large values.
  assign in_bad  = (addr[1:0] != 2'b00) || ((addr - BASE_ADDR) >= SPAN);
  assign txn_bad = (state == ST_IDLE) ? in_bad : lat_bad;
  assign err     = err_q;

  // Latch the address verdict at acceptance and present it in the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_bad <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) lat_bad <= in_bad;
      err_q <= commit && txn_bad;
    end
  end
`else
  assign txn_bad = 1'b0;
  assign err     = 1'b0;
`endif

  assign mem_we = commit && txn_we && !txn_bad;
  assign ready  = (state == ST_RESP);
  assign busy   = (state != ST_IDLE);

  // Next-state logic. commit marks the edge that enters RESP.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    commit       = 1'b0;
    case (state)
      ST_IDLE: begin
        // rst is checked here so that a request held high during reset
        // cannot write the array when there are no wait states.
        if (req && rst) begin
          if (HAS_WAIT) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end else begin
            state_nxt = ST_RESP;
            commit    = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = ST_RESP;
          commit    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, wait counter, request latches and registered load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      rdata     <= 32'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
      end
      rdata <= (commit && !txn_we && !txn_bad) ? mem[txn_idx] : 32'd0;
    end
  end

  // Storage array. It has no reset, and stores land on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (mem_we) mem[txn_idx] <= txn_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. One instance uses 2 wait states and one uses none.
// A word-array model tracks the expected memory contents and computes the
// expected response timing.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        busy  [2];

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [2][256];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut_w2 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ready(ready[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ready(ready[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
    return (a % 4 != 0) || (a >= 32'd1024);
`else
    return 1'b0;
`endif
  endfunction

  // Runs one transaction on instance d, starting from an idle cycle.
  // scr: in the first cycle after acceptance, drive we/wdata to random values
  // and addr to scr_addr. If drop is also set, req falls at that point.
  // hold: leave req high after ready so that the next call is back-to-back.
  task automatic txn(input int d, input logic t_we, input logic [31:0] t_addr,
                     input logic [31:0] t_wdata, input bit hold, input bit scr,
                     input bit drop, input logic [31:0] scr_addr);
    int          w;
    int          idx;
    logic        b;
    logic [31:0] exp_rd;
    w   = (d == 0) ? 2 : 0;
    idx = int'((t_addr >> 2) % 256);
    b   = addr_bad(t_addr);
    exp_rd = (!t_we && !b) ? mdl[d][idx] : 32'd0;
    @(negedge clk);
    chk($sformatf("idle_ready_d%0d", d), 32'(ready[d]), 32'd0);
    chk($sformatf("idle_rdata_d%0d", d), rdata[d], 32'd0);
    chk($sformatf("idle_busy_d%0d", d), 32'(busy[d]), 32'd0);
    req[d] = 1'b1; we[d] = t_we; addr[d] = t_addr; wdata[d] = t_wdata;
    @(posedge clk);
    if (t_we && !b) mdl[d][idx] = t_wdata;
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge clk);
      chk($sformatf("ready_d%0d_k%0d", d, k), 32'(ready[d]), (k == w + 1) ? 32'd1 : 32'd0);
      chk($sformatf("busy_d%0d_k%0d", d, k), 32'(busy[d]), 32'd1);
      chk($sformatf("rdata_d%0d_k%0d_a%h", d, k, t_addr), rdata[d], (k == w + 1) ? exp_rd : 32'd0);
      chk($sformatf("err_d%0d_k%0d_a%h", d, k, t_addr), 32'(err[d]), (k == w + 1) ? 32'(b) : 32'd0);
      if (k == 1 && scr) begin
        addr[d]  = scr_addr;
        wdata[d] = $urandom;
        we[d]    = 1'($urandom);
        if (drop) req[d] = 1'b0;
      end
      if (k == w + 1 && !hold) req[d] = 1'b0;
    end
  endtask

  initial begin
    int d;
    int nd;
    logic [31:0] a;
    bit hold;

    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset held with a request pending on both instances.
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b1; we[i] = 1'b1; addr[i] = 32'h10; wdata[i] = 32'h0BAD;
    end
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rst_ready_d%0d", i), 32'(ready[i]), 32'd0);
        chk($sformatf("rst_busy_d%0d", i), 32'(busy[i]), 32'd0);
        chk($sformatf("rst_rdata_d%0d", i), rdata[i], 32'd0);
        chk($sformatf("rst_err_d%0d", i), 32'(err[i]), 32'd0);
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy_d0", 32'(busy[0]), 32'd0);
    chk("post_rst_busy_d1", 32'(busy[1]), 32'd0);

    // Store then load with 2 wait states.
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 0, 0, 0, 32'h0);

    // Back-to-back with req held high across the ready cycle.
    txn(0, 1'b1, 32'h4, 32'h1, 1, 0, 0, 32'h0);
    txn(0, 1'b0, 32'h4, 32'h0, 0, 0, 0, 32'h0);

    // No wait states; addr moves to 0xC right after acceptance.
    txn(1, 1'b1, 32'hC, 32'h0C0C_0C0C, 0, 0, 0, 32'h0);
    txn(1, 1'b1, 32'h8, 32'h1234_5678, 0, 1, 0, 32'hC);
    txn(1, 1'b0, 32'h8, 32'h0, 0, 0, 0, 32'h0);
    txn(1, 1'b0, 32'hC, 32'h0, 0, 0, 0, 32'h0);

    // Reset during the WAIT phase of a store: no ready, no commit.
    txn(0, 1'b1, 32'h20, 32'h5, 0, 0, 0, 32'h0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFE_0000;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy_before", 32'(busy[0]), 32'd1);
    rst = 1'b0; req[0] = 1'b0;
    #1;
    chk("midrst_busy_async", 32'(busy[0]), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_ready", 32'(ready[0]), 32'd0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_after_ready", 32'(ready[0]), 32'd0);
    end
    txn(0, 1'b0, 32'h20, 32'h0, 0, 0, 0, 32'h0);

`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
    txn(0, 1'b1, 32'h0,   32'hA5A5_0000, 0, 0, 0, 32'h0);
    txn(0, 1'b1, 32'h3FC, 32'h0003_FC00, 0, 0, 0, 32'h0);
    txn(0, 1'b1, 32'h402, 32'h7, 0, 0, 0, 32'h0);
    txn(0, 1'b1, 32'h400, 32'h99, 0, 0, 0, 32'h0);
    txn(0, 1'b0, 32'h0,   32'h0, 0, 0, 0, 32'h0);
    txn(0, 1'b0, 32'h3FC, 32'h0, 0, 0, 0, 32'h0);
`endif

    // Fill words 0..15 on both instances before the random loads.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++)
        txn(i, 1'b1, 32'(j * 4), $urandom, 0, 0, 0, 32'h0);

    // Random mix of loads and stores. It includes wrapped and misaligned
    // addresses, early req drop, input scrambling and back-to-back holds.
    nd = int'($urandom_range(1, 0));
    for (int i = 0; i < 60; i++) begin
      d  = nd;
      nd = int'($urandom_range(1, 0));
      a  = 32'($urandom_range(15, 0) * 4);
      if ($urandom_range(3, 0) == 0) a = a + 32'($urandom_range(3, 0) * 1024);
      if ($urandom_range(3, 0) == 0) a = a + 32'($urandom_range(3, 0));
      hold = (nd == d) && ($urandom_range(1, 0) == 1) && (i != 59);
      txn(d, 1'($urandom), a, $urandom, hold, 1'($urandom), 1'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
